// File: rtl/pc_unit.sv
// Program counter with stall, gated interrupt entry, EPC capture, jump-register
// kernel protection and a registered flush pulse for the fetch pipeline.
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h00000000,
  parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h80000004,
  parameter logic [WIDTH-1:0] XADR_VEC  = 32'h80000008
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic [2:0]       i_pc_src,
  input  logic             i_alu_zero,
  input  logic [WIDTH-1:0] i_con_ba,
  input  logic [WIDTH-1:0] i_jt,
  input  logic [WIDTH-1:0] i_data_bus_a,
  input  logic             i_irq,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus_inc,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_kernel,
  output logic             o_flush,
  output logic             o_irq_taken
);

  localparam logic [WIDTH-1:0] LP_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LP_INC_FULL = WIDTH'(INC);
  localparam logic [WIDTH-2:0] LP_INC = LP_INC_FULL[WIDTH-2:0];

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_irq_pending;
  logic             r_flush;

  logic [WIDTH-1:0] w_pc_plus_inc;
  logic [WIDTH-1:0] w_pc_msb;
  logic [WIDTH-1:0] w_br_target;
  logic [WIDTH-1:0] w_j_target;
  logic [WIDTH-1:0] w_jr_target;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_next_epc;
  logic             w_epc_we;
  logic             w_kernel;
  logic             w_irq_taken;

  assign w_kernel      = r_pc[WIDTH-1];
  // The supervisor bit never receives a carry from the low-order increment.
  assign w_pc_plus_inc = {r_pc[WIDTH-1], r_pc[WIDTH-2:0] + LP_INC};
  assign w_pc_msb      = r_pc & LP_MSB;
  assign w_br_target   = (i_con_ba & ~LP_MSB) | w_pc_msb;
  assign w_j_target    = (i_jt & ~LP_MSB) | w_pc_msb;
  // User code cannot reach kernel space through a register jump.
  assign w_jr_target   = w_kernel ? i_data_bus_a : (i_data_bus_a & ~LP_MSB);
  assign w_irq_taken   = r_irq_pending & ~i_stall & ~w_kernel & ~i_reset;

  always_comb begin
    w_next_pc  = w_pc_plus_inc;
    w_next_epc = w_pc_plus_inc;
    w_epc_we   = 1'b0;
    if (w_irq_taken) begin
      w_next_pc  = XADR_VEC;
      w_next_epc = r_pc;
      w_epc_we   = 1'b1;
    end else begin
      case (i_pc_src)
        3'd0: w_next_pc = w_pc_plus_inc;
        3'd1: w_next_pc = i_alu_zero ? w_br_target : w_pc_plus_inc;
        3'd2: w_next_pc = w_j_target;
        3'd3: w_next_pc = w_jr_target;
        3'd5: begin
          w_next_pc = XADR_VEC;
          w_epc_we  = 1'b1;
        end
        default: begin
          w_next_pc = ILLOP_VEC;
          w_epc_we  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_VEC;
      r_epc         <= '0;
      r_irq_pending <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_irq_pending <= w_irq_taken ? 1'b0 : (r_irq_pending | i_irq);
      if (i_stall) begin
        r_flush <= 1'b0;
      end else begin
        r_pc    <= w_next_pc;
        r_flush <= (w_next_pc != w_pc_plus_inc);
        if (w_epc_we) r_epc <= w_next_epc;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus_inc = w_pc_plus_inc;
  assign o_epc         = r_epc;
  assign o_kernel      = w_kernel;
  assign o_flush       = r_flush;
  assign o_irq_taken   = w_irq_taken;

endmodule
